// File: rtl/popcount_accum.sv
// popcount_accum: streams WIDTH-bit words, registers the population count of
// each accepted word and accumulates those counts over a frame. The frame
// total saturates at 2^ACC_W-1. It is presented on a held result handshake
// together with the frame's word count and a sticky saturation flag.
//
// Handshake semantics (both interfaces): a transfer happens on a rising edge
// where valid && ready. A producer holding valid keeps its payload stable
// until that edge. in_ready is registered and depends only on internal state.
// out_valid, once raised, stays high with stable out_sum/out_words/out_sat
// until the edge where out_ready is sampled high.
module popcount_accum #(
    parameter int WIDTH     = 10,
    parameter int ACC_W     = 16,
    parameter int FRAME_LEN = 20
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    input  logic [WIDTH-1:0]                 in_data,
    input  logic                             in_last,
    output logic                             in_ready,
    output logic                             pc_valid,
    output logic [$clog2(WIDTH+1)-1:0]       pc_data,
    output logic                             out_valid,
    output logic [ACC_W-1:0]                 out_sum,
    output logic [$clog2(FRAME_LEN+1)-1:0]   out_words,
    output logic                             out_sat,
    input  logic                             out_ready
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int WC_W  = $clog2(FRAME_LEN + 1);

    // ACCUM takes words. DRAIN lets the last registered popcount land in the
    // accumulator. LOAD copies the settled totals into the result registers.
    // HOLD presents the result until it is taken.
    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_DRAIN = 2'd1,
        ST_LOAD  = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    state_e                 state_q;

    // Per-word stage registers
    logic                   pc_valid_q;
    logic [CNT_W-1:0]       pc_data_q;
    logic [CNT_W-1:0]       ones_d;

    // Frame accumulation registers
    logic [ACC_W-1:0]       acc_q,  acc_d;
    logic                   sat_q,  sat_d;
    logic [WC_W-1:0]        wcnt_q, wcnt_d;
    logic [ACC_W:0]         acc_sum;

    // Registered handshake and result outputs
    logic                   in_ready_q;
    logic                   out_valid_q;
    logic [ACC_W-1:0]       out_sum_q;
    logic [WC_W-1:0]        out_words_q;
    logic                   out_sat_q;

    // Transfer qualifiers
    logic                   accept;
    logic                   closing;
    logic                   result_taken;

    assign accept       = in_valid && in_ready_q;
    // The word that fills the frame closes it even without in_last.
    assign closing      = accept && (in_last || (wcnt_q == WC_W'(FRAME_LEN - 1)));
    assign result_taken = (state_q == ST_HOLD) && out_valid_q && out_ready;

    // Count the ones of the incoming word.
    always_comb begin
        ones_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ones_d = ones_d + CNT_W'(in_data[i]);
        end
    end

    // Register the popcount of each accepted word as a one-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_valid_q <= 1'b0;
            pc_data_q  <= '0;
        end else begin
            pc_valid_q <= accept;
            if (accept) begin
                pc_data_q <= ones_d;
            end
        end
    end

    // Next frame totals: add the registered popcount with saturation, count
    // accepted words, and clear everything once the result has been taken.
    always_comb begin
        acc_sum = {1'b0, acc_q} + (ACC_W + 1)'(pc_data_q);
        acc_d   = acc_q;
        sat_d   = sat_q;
        wcnt_d  = wcnt_q;
        if (pc_valid_q) begin
            if (acc_sum[ACC_W]) begin
                acc_d = '1;
                sat_d = 1'b1;
            end else begin
                acc_d = acc_sum[ACC_W-1:0];
            end
        end
        if (accept) begin
            wcnt_d = wcnt_q + WC_W'(1);
        end
        if (result_taken) begin
            acc_d  = '0;
            sat_d  = 1'b0;
            wcnt_d = '0;
        end
    end

    // Hold the frame accumulator, sticky saturation flag and word counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            sat_q  <= 1'b0;
            wcnt_q <= '0;
        end else begin
            acc_q  <= acc_d;
            sat_q  <= sat_d;
            wcnt_q <= wcnt_d;
        end
    end

    // Frame control FSM with registered in_ready and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACCUM;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_words_q <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (closing) begin
                        in_ready_q <= 1'b0;
                        state_q    <= ST_DRAIN;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // The closing word's popcount is being added this cycle.
                    in_ready_q <= 1'b0;
                    state_q    <= ST_LOAD;
                end
                ST_LOAD: begin
                    in_ready_q  <= 1'b0;
                    out_sum_q   <= acc_q;
                    out_words_q <= wcnt_q;
                    out_sat_q   <= sat_q;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (result_taken) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_ACCUM;
                    end
                end
                default: begin
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    state_q     <= ST_ACCUM;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign pc_valid  = pc_valid_q;
    assign pc_data   = pc_data_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_words = out_words_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_popcount_accum.sv
// Bench for popcount_accum. Three instances share one clock, reset and
// stimulus stream: the default configuration (a), a 5-bit accumulator (b)
// that saturates, and a WIDTH=1 bit counter (c) fed with bit 0 of each word.
// A frame-level reference model predicts popcounts, totals, word counts and
// handshake timing from the block's stated rules.
module tb_popcount_accum;

    localparam int FRAME_LEN = 20;
    localparam int SAT_B     = 31;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [9:0]  in_data = '0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready_a, pc_valid_a, out_valid_a, out_sat_a;
    logic [3:0]  pc_data_a;
    logic [15:0] out_sum_a;
    logic [4:0]  out_words_a;

    logic        in_ready_b, pc_valid_b, out_valid_b, out_sat_b;
    logic [3:0]  pc_data_b;
    logic [4:0]  out_sum_b;
    logic [4:0]  out_words_b;

    logic        in_ready_c, pc_valid_c, out_valid_c, out_sat_c;
    logic [0:0]  pc_data_c;
    logic [15:0] out_sum_c;
    logic [4:0]  out_words_c;

    popcount_accum #(.WIDTH(10), .ACC_W(16), .FRAME_LEN(FRAME_LEN)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready_a), .pc_valid(pc_valid_a),
        .pc_data(pc_data_a), .out_valid(out_valid_a), .out_sum(out_sum_a),
        .out_words(out_words_a), .out_sat(out_sat_a), .out_ready(out_ready)
    );

    popcount_accum #(.WIDTH(10), .ACC_W(5), .FRAME_LEN(FRAME_LEN)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready_b), .pc_valid(pc_valid_b),
        .pc_data(pc_data_b), .out_valid(out_valid_b), .out_sum(out_sum_b),
        .out_words(out_words_b), .out_sat(out_sat_b), .out_ready(out_ready)
    );

    popcount_accum #(.WIDTH(1), .ACC_W(16), .FRAME_LEN(FRAME_LEN)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data[0:0]),
        .in_last(in_last), .in_ready(in_ready_c), .pc_valid(pc_valid_c),
        .pc_data(pc_data_c), .out_valid(out_valid_c), .out_sum(out_sum_c),
        .out_words(out_words_c), .out_sat(out_sat_c), .out_ready(out_ready)
    );

    // Clock
    always #5 clk = ~clk;

    // Reference model state
    typedef struct {
        int sum_a;
        int sum_b;
        bit sat_b;
        int sum_c;
        int words;
    } res_t;

    logic [3:0] exp_q[$];
    res_t       res_q[$];
    bit         m_ready = 1'b0;
    bit         m_ovalid = 1'b0;
    bit         m_wake = 1'b0;
    int         m_cd = 0;
    int         m_ones = 0;
    int         m_ones_c = 0;
    int         m_words = 0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        res_q.delete();
        m_ready  = 1'b0;
        m_ovalid = 1'b0;
        m_cd     = 0;
        m_ones   = 0;
        m_ones_c = 0;
        m_words  = 0;
        m_wake   = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " in_ready_a"},  32'(in_ready_a), 0);
        check({tag, " in_ready_c"},  32'(in_ready_c), 0);
        check({tag, " pc_valid_a"},  32'(pc_valid_a), 0);
        check({tag, " pc_data_a"},   32'(pc_data_a), 0);
        check({tag, " out_valid_a"}, 32'(out_valid_a), 0);
        check({tag, " out_valid_b"}, 32'(out_valid_b), 0);
        check({tag, " out_sum_a"},   32'(out_sum_a), 0);
        check({tag, " out_sum_b"},   32'(out_sum_b), 0);
        check({tag, " out_words_a"}, 32'(out_words_a), 0);
        check({tag, " out_sat_b"},   32'(out_sat_b), 0);
    endtask

    // One clock of stimulus: drive, advance past the edge, update the model, check.
    task automatic cycle(input logic v, input logic [9:0] d, input logic l,
                         input logic r, output bit accepted);
        bit         hs;
        int         pc_c;
        logic [3:0] exp_pc;
        res_t       res;
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = r;
        accepted  = v && m_ready;
        hs        = m_ovalid && r;
        pc_c      = int'(d[0]);
        if (accepted) exp_q.push_back(4'($countones(d)));
        @(posedge clk);
        #1;
        if (m_wake) begin
            m_ready = 1'b1;
            m_wake  = 1'b0;
        end
        if (m_cd > 0) begin
            m_cd--;
            if (m_cd == 0) m_ovalid = 1'b1;
        end
        if (hs) begin
            m_ovalid = 1'b0;
            m_ready  = 1'b1;
            if (res_q.size() > 0) void'(res_q.pop_front());
        end
        if (accepted) begin
            m_ones   += $countones(d);
            m_ones_c += pc_c;
            m_words++;
            if (l || m_words == FRAME_LEN) begin
                res.sum_a = m_ones;
                res.sum_b = (m_ones > SAT_B) ? SAT_B : m_ones;
                res.sat_b = (m_ones > SAT_B);
                res.sum_c = m_ones_c;
                res.words = m_words;
                res_q.push_back(res);
                m_ones   = 0;
                m_ones_c = 0;
                m_words  = 0;
                m_ready  = 1'b0;
                m_cd     = 2;
            end
        end
        check("in_ready_a", 32'(in_ready_a), 32'(m_ready));
        check("in_ready_b", 32'(in_ready_b), 32'(m_ready));
        check("in_ready_c", 32'(in_ready_c), 32'(m_ready));
        if (accepted) begin
            exp_pc = exp_q.pop_front();
            check("pc_valid_a", 32'(pc_valid_a), 1);
            check("pc_valid_c", 32'(pc_valid_c), 1);
            check("pc_data_a",  32'(pc_data_a), 32'(exp_pc));
            check("pc_data_b",  32'(pc_data_b), 32'(exp_pc));
            check("pc_data_c",  32'(pc_data_c), 32'(pc_c));
        end else begin
            check("pc_valid_a idle", 32'(pc_valid_a), 0);
            check("pc_valid_b idle", 32'(pc_valid_b), 0);
            check("pc_valid_c idle", 32'(pc_valid_c), 0);
        end
        check("out_valid_a", 32'(out_valid_a), 32'(m_ovalid));
        check("out_valid_b", 32'(out_valid_b), 32'(m_ovalid));
        check("out_valid_c", 32'(out_valid_c), 32'(m_ovalid));
        if (m_ovalid && res_q.size() > 0) begin
            res = res_q[0];
            check("out_sum_a",   32'(out_sum_a), 32'(res.sum_a));
            check("out_words_a", 32'(out_words_a), 32'(res.words));
            check("out_sat_a",   32'(out_sat_a), 0);
            check("out_sum_b",   32'(out_sum_b), 32'(res.sum_b));
            check("out_sat_b",   32'(out_sat_b), 32'(res.sat_b));
            check("out_words_b", 32'(out_words_b), 32'(res.words));
            check("out_sum_c",   32'(out_sum_c), 32'(res.sum_c));
            check("out_words_c", 32'(out_words_c), 32'(res.words));
            check("out_sat_c",   32'(out_sat_c), 0);
        end
    endtask

    // Idle with a given out_ready until the block can take a word (bounded).
    task automatic wait_ready(input logic r);
        bit acc;
        int n = 0;
        while (!m_ready && n < 40) begin
            cycle(1'b0, '0, 1'b0, r, acc);
            n++;
        end
        if (!m_ready) check("wait_ready timeout", 0, 1);
    endtask

    task automatic send_word(input logic [9:0] d, input logic l, input logic r);
        bit acc;
        wait_ready(r);
        cycle(1'b1, d, l, r, acc);
    endtask

    task automatic idle(input int n, input logic r);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, r, acc);
    endtask

    // Assert reset between edges, check outputs clear at once, then release.
    task automatic mid_reset(input string tag);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero(tag);
        clear_model();
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #5;
        rst_n = 1'b1;
        #1;
        check({tag, " in_ready at release"}, 32'(in_ready_a), 0);
    endtask

    initial begin
        bit acc;
        int accepted_n;
        int n;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        #4;
        rst_n = 1'b1;
        clear_model();

        // 20 single-word frames of all ones
        for (int i = 0; i < 20; i++) send_word(10'h3FF, 1'b1, 1'b1);
        idle(4, 1'b1);

        // 20 words without in_last: frame closes on the 20th word
        for (int i = 0; i < 20; i++) send_word(10'b0000000101, 1'b0, 1'b1);
        idle(4, 1'b1);

        // Backpressure: result held for 5 cycles, then one handshake
        send_word(10'b1100110011, 1'b0, 1'b0);
        send_word(10'b0000000001, 1'b0, 1'b0);
        send_word(10'b1010101010, 1'b1, 1'b0);
        n = 0;
        while (!m_ovalid && n < 10) begin
            cycle(1'b0, '0, 1'b0, 1'b0, acc);
            n++;
        end
        if (!m_ovalid) check("out_valid timeout", 0, 1);
        idle(5, 1'b0);
        idle(1, 1'b1);
        send_word(10'b0000000011, 1'b0, 1'b1);
        send_word(10'b1000000000, 1'b1, 1'b1);
        idle(4, 1'b1);

        // Saturation in the 5-bit accumulator, then a clean frame
        for (int i = 0; i < 4; i++) send_word(10'h3FF, (i == 3), 1'b1);
        send_word(10'b0000000001, 1'b1, 1'b1);
        idle(4, 1'b1);

        // Reset mid-frame after 3 accepted words, then a 2-word frame
        for (int i = 0; i < 3; i++) send_word(10'h2A5, 1'b0, 1'b1);
        mid_reset("mid_frame");
        send_word(10'b0000001111, 1'b0, 1'b1);
        send_word(10'b0000001111, 1'b1, 1'b1);
        idle(4, 1'b1);

        // Reset while a result is held
        send_word(10'h0F0, 1'b1, 1'b0);
        idle(3, 1'b0);
        mid_reset("mid_hold");
        idle(2, 1'b1);

        // Random words, random in_last and out_ready
        accepted_n = 0;
        n = 0;
        while (accepted_n < 200 && n < 5000) begin
            cycle(($urandom_range(0, 3) != 0), 10'($urandom), ($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 1)), acc);
            if (acc) accepted_n++;
            n++;
        end
        if (accepted_n < 200) check("random accept budget", 32'(accepted_n), 200);
        send_word(10'h155, 1'b1, 1'b1);
        idle(5, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/popcount_accum.md
Name: popcount_accum

Overview:
- Sequential, parametrised successor to the team's 10-input ones-counter.
- Accepts a stream of WIDTH-bit words over a valid/ready handshake.
- Registers each word's population count and accumulates the counts over a frame.
- Presents a saturating frame total on a held output handshake; sits between a bit-vector source and the statistics/report logic.

Parameters:
- WIDTH, 10, input word width in bits (>=1). Local CNT_W = $clog2(WIDTH+1); default 4, i.e. the cout2,cout1,cout0,sum weighting.
- ACC_W, 16, frame accumulator width (>= CNT_W).
- FRAME_LEN, 20, maximum words per frame (>=1); the frame closes early on in_last.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input word valid
- in_data  in  WIDTH  input word
- in_last  in  1  last word of frame, qualified by in_valid
- in_ready  out  1  block can accept a word
- pc_valid  out  1  pc_data valid, one-cycle pulse
- pc_data  out  CNT_W  popcount of the most recently accepted word
- out_valid  out  1  frame result valid
- out_sum  out  ACC_W  frame total of ones
- out_words  out  $clog2(FRAME_LEN+1)  words in frame
- out_sat  out  1  accumulator saturated during frame
- out_ready  in  1  consumer accepts result

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: all outputs 0 except in_ready; internal acc, word counter and sat flag 0; FSM = ACCUM. in_ready is 0 during reset and 1 in the first cycle after rst_n deasserts.
- Accept: a word is accepted when in_valid && in_ready on a rising edge.
- Per-word stage: at an accept, pc_data <= number of 1s in in_data (0..WIDTH) and pc_valid <= 1 for one cycle. Latency is 1 cycle.
- Accumulate stage: when pc_valid=1, acc <= acc + pc_data. If the sum exceeds 2^ACC_W-1, acc <= 2^ACC_W-1 and the sat flag is set (sticky for the frame). Word counter increments at each accept.
- Frame close: an accepted word closes the frame if in_last=1 or the word counter reaches FRAME_LEN with that word.
- FSM states:
  - ACCUM: in_ready=1. A closing accept moves to DRAIN.
  - DRAIN: in_ready=0, one cycle. The final pc_data is added. Then out_sum/out_words/out_sat are loaded from the final values, out_valid <= 1, and the FSM moves to HOLD.
  - HOLD: in_ready=0; outputs stable. On out_valid && out_ready: out_valid <= 0, acc/word counter/sat cleared, next state ACCUM.
- Latency: closing word accepted at edge T -> out_valid high after edge T+2. The next word can be accepted at the edge after the out_ready handshake.
- Single-word frame (in_last on the first word) is legal; out_words = 1.
- in_last with in_valid=0 is ignored. in_data and in_last are don't-care when in_valid=0.
- out_ready held high continuously: HOLD lasts exactly 1 cycle, giving a 3-cycle dead time between frames.
- Reset mid-frame or mid-HOLD aborts the frame: no partial result is emitted and the state returns to reset values immediately.
- WIDTH=1: CNT_W=1 and the block degenerates to a bit counter; must still meet all rules above.

Test Plan:
- 20 frames of 1 word each, in_data=10'b1111111111, in_last=1, out_ready=1 -> each word gives pc_data=10 (4'b1010) one cycle after accept; each frame gives out_sum=10, out_words=1, out_valid 2 cycles after accept.
- FRAME_LEN=20, 20 words of 10'b0000000101 with in_last=0 -> frame auto-closes on word 20; out_sum=40, out_words=20, out_sat=0.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> in_ready=0 and outputs stable throughout. Release -> one handshake, in_ready=1 on the next cycle, next frame total independent of the previous one.
- Saturation with ACC_W=5: 4 words of all-ones (sum 40) -> out_sum=31, out_sat=1. The following frame of 10'b1 gives out_sum=1, out_sat=0.
- Reset mid-frame: assert rst_n=0 asynchronously (between edges) after 3 accepted words -> outputs 0 immediately. After release, a 2-word frame of 10'b0000001111 gives out_sum=8, out_words=2.
- Random: 200 $random words with random in_last and random out_ready -> scoreboard reference popcount sums match; no word accepted while in_ready=0.
